// File: rtl/s32x_sdr_bridge_pkg.sv
// Shared types for the 32X SH-2 SDRAM bridge: FSM states, write-buffer entry,
// read-hit register and the byte-merge helper.
package s32x_sdr_bridge_pkg;

    localparam int SDR_AW = 17;
    localparam int SDR_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic [SDR_AW-1:0] addr;
        logic [SDR_DW-1:0] data;
        logic [1:0]        be;
    } wbuf_t;

    typedef struct packed {
        logic              valid;
        logic [SDR_AW-1:0] addr;
        logic [SDR_DW-1:0] data;
    } hit_t;

    // Replace the enabled bytes of old_d with those of new_d.
    function automatic logic [SDR_DW-1:0] merge_bytes(input logic [SDR_DW-1:0] old_d,
                                                      input logic [SDR_DW-1:0] new_d,
                                                      input logic [1:0]        be);
        merge_bytes = {be[1] ? new_d[15:8] : old_d[15:8],
                       be[0] ? new_d[7:0]  : old_d[7:0]};
    endfunction

endpackage

// File: rtl/s32x_sdr_bridge.sv
// SH-2 SDRAM strobe bus to request/acknowledge bridge with a one-deep posted
// write buffer and a single-word read-hit register.
module s32x_sdr_bridge
    import s32x_sdr_bridge_pkg::*;
#(
    parameter bit RD_HIT_EN = 1'b1,
    parameter int MEM_AW    = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [16:0]       SDR_A,
    input  logic [15:0]       SDR_DO,
    input  logic              SDR_CS,
    input  logic [1:0]        SDR_WE,
    input  logic              SDR_RD,
    output logic [15:0]       SDR_DI,
    output logic              SDR_WAIT,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DO,
    output logic [1:0]        MEM_BE,
    output logic              MEM_WR,
    output logic              MEM_REQ,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DI
);

    bridge_state_e state_q, state_d;
    wbuf_t         wb_q, wb_d;
    logic          wb_vld_q, wb_vld_d;
    hit_t          hit_q, hit_d;
    logic          served_q, served_d;
    logic [16:0]   srv_a_q;
    logic          srv_rd_q;
    logic [1:0]    srv_we_q;
    logic          mem_req_q, mem_req_d;
    logic          mem_wr_q;
    logic [16:0]   mem_addr_q;
    logic [15:0]   mem_do_q;
    logic [1:0]    mem_be_q;
    logic [15:0]   sdr_di_q;

    logic acc, is_wr, is_rd, srv_live, fresh;
    logic ack_wr, ack_rd, hit_match, rd_hit, rd_ack;
    logic wr_rdy, ready, wr_acc, rd_done, rd_miss;
    logic enter_wr, enter_rd;

    assign acc   = SDR_CS & (SDR_RD | (SDR_WE != 2'b00));
    assign is_wr = (SDR_WE != 2'b00);
    assign is_rd = SDR_RD & ~is_wr;

    // The served flag only holds while the SH-2 keeps presenting the same access.
    assign srv_live = served_q & acc & (SDR_A == srv_a_q) & (SDR_RD == srv_rd_q)
                    & (SDR_WE == srv_we_q);
    assign fresh    = acc & ~srv_live;

    assign ack_wr    = MEM_ACK & mem_req_q & (state_q == WR_REQ);
    assign ack_rd    = MEM_ACK & mem_req_q & (state_q == RD_REQ);
    assign hit_match = RD_HIT_EN & hit_q.valid & (hit_q.addr == SDR_A);
    assign rd_hit    = is_rd & hit_match & ~wb_vld_q;
    // A returning read only serves a current read of the same word with no newer write queued.
    assign rd_ack    = is_rd & ack_rd & (mem_addr_q == SDR_A) & ~wb_vld_q;

    assign wr_rdy   = ~wb_vld_q | ack_wr;
    assign ready    = is_wr ? wr_rdy : (rd_hit | rd_ack);
    assign SDR_WAIT = fresh & ~ready;
    assign wr_acc   = fresh & is_wr & wr_rdy;
    assign rd_done  = fresh & (rd_hit | rd_ack);
    assign rd_miss  = fresh & is_rd & ~hit_match;

    assign SDR_DI = ack_rd ? MEM_DI : (rd_hit ? hit_q.data : sdr_di_q);

    always_comb begin
        wb_vld_d = wb_vld_q;
        wb_d     = wb_q;
        if (ack_wr) wb_vld_d = 1'b0;
        if (wr_acc) begin
            wb_vld_d  = 1'b1;
            wb_d.addr = SDR_A;
            wb_d.data = SDR_DO;
            wb_d.be   = SDR_WE;
        end
    end

    // Read fill first, then any write accepted this cycle merges on top of it.
    always_comb begin
        hit_d = hit_q;
        if (ack_rd) begin
            hit_d.valid = 1'b1;
            hit_d.addr  = mem_addr_q;
            hit_d.data  = (wb_vld_q && wb_q.addr == mem_addr_q)
                        ? merge_bytes(MEM_DI, wb_q.data, wb_q.be) : MEM_DI;
        end
        if (wr_acc && hit_d.valid && hit_d.addr == SDR_A)
            hit_d.data = merge_bytes(hit_d.data, SDR_DO, SDR_WE);
        hit_d.valid = hit_d.valid & RD_HIT_EN;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb_vld_d)     state_d = WR_REQ;
                else if (rd_miss) state_d = RD_REQ;
            end
            WR_REQ: if (ack_wr) state_d = rd_miss ? RD_REQ : IDLE;
            RD_REQ: if (ack_rd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request drops for one cycle after every ACK, even when chaining WR_REQ into RD_REQ.
    assign mem_req_d = (state_d != IDLE) & ~(ack_wr | ack_rd);
    assign served_d  = (wr_acc | rd_done) ? 1'b1 : srv_live;
    assign enter_wr  = (state_d == WR_REQ) & (state_q != WR_REQ);
    assign enter_rd  = (state_d == RD_REQ) & (state_q != RD_REQ);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            wb_vld_q   <= 1'b0;
            wb_q       <= '0;
            hit_q      <= '0;
            served_q   <= 1'b0;
            srv_a_q    <= '0;
            srv_rd_q   <= 1'b0;
            srv_we_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_do_q   <= '0;
            mem_be_q   <= '0;
            sdr_di_q   <= '0;
        end else begin
            state_q   <= state_d;
            wb_vld_q  <= wb_vld_d;
            wb_q      <= wb_d;
            hit_q     <= hit_d;
            served_q  <= served_d;
            mem_req_q <= mem_req_d;
            if (wr_acc || rd_done) begin
                srv_a_q  <= SDR_A;
                srv_rd_q <= SDR_RD;
                srv_we_q <= SDR_WE;
            end
            if (enter_wr) begin
                mem_addr_q <= wb_d.addr;
                mem_do_q   <= wb_d.data;
                mem_be_q   <= wb_d.be;
                mem_wr_q   <= 1'b1;
            end else if (enter_rd) begin
                mem_addr_q <= SDR_A;
                mem_be_q   <= 2'b11;
                mem_wr_q   <= 1'b0;
            end
            if (ack_rd)      sdr_di_q <= MEM_DI;
            else if (rd_hit) sdr_di_q <= hit_q.data;
        end
    end

    assign MEM_REQ  = mem_req_q;
    assign MEM_WR   = mem_wr_q;
    assign MEM_ADDR = MEM_AW'(mem_addr_q);
    assign MEM_DO   = mem_do_q;
    assign MEM_BE   = mem_be_q;

endmodule
